// File: rtl/wb_stream_fifo.sv
// wb_stream_fifo: Wishbone slave that buffers the 9-bit stream from the
// SPI-flash bridge and exposes it through DATA/STATUS/THRESH/CTRL registers.
// Optional build macro WB_STREAM_FIFO_TS_EN stores a 15-bit cycle timestamp
// with every word and returns it in DATA[30:16].
module wb_stream_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        p_reset_n,
  input  logic [8:0]  st_o,
  input  logic        st_stb,
  output logic        st_busy,
  input  logic [14:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic        we_i,
  input  logic        stb_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq
);

`ifdef WB_STREAM_FIFO_TS_EN
  localparam int ENTRY_W = 24;
`else
  localparam int ENTRY_W = 9;
`endif
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [8:0]            count_ext;
  logic [8:0]            thresh;
  logic                  en, ovf, cond, cond_q;
  logic                  full, empty;
  logic                  access, bus_wr, bus_rd, push, pop, flush;
  logic [ENTRY_W-1:0]    entry, head;
  logic [14:0]           rd_ts;
  logic [31:0]           rdata;
  logic                  unused_bits;

  assign unused_bits = ^{adr_i[14:2], dat_i[31:9]};

  assign count_ext = 9'(count);
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign st_busy   = en & full;

  // A new access starts only while no ack is outstanding, so a held strobe
  // yields one access every two cycles.
  assign access = stb_i & ~ack_o;
  assign bus_wr = access & we_i;
  assign bus_rd = access & ~we_i;
  assign push   = st_stb & en & ~full;
  assign pop    = bus_rd & (adr_i[1:0] == 2'd0) & ~empty;
  assign flush  = bus_wr & (adr_i[1:0] == 2'd3) & dat_i[1];
  assign head   = mem[rd_ptr];

`ifdef WB_STREAM_FIFO_TS_EN
  logic [14:0] ts_cnt;

  // Free-running cycle counter used as the per-word timestamp.
  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) ts_cnt <= '0;
    else            ts_cnt <= ts_cnt + 15'd1;
  end

  assign entry = {ts_cnt, st_o};
  assign rd_ts = head[23:9];
`else
  assign entry = st_o;
  assign rd_ts = 15'd0;
`endif

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // Pointer and occupancy update; flush overrides a same-cycle push.
  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control registers and the sticky overflow flag (a new drop beats a clear).
  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      en     <= 1'b1;
      thresh <= '0;
      ovf    <= 1'b0;
    end else begin
      if (st_stb & en & full)
        ovf <= 1'b1;
      else if (bus_wr & (adr_i[1:0] == 2'd1) & dat_i[2])
        ovf <= 1'b0;
      if (bus_wr & (adr_i[1:0] == 2'd2)) thresh <= dat_i[8:0];
      if (bus_wr & (adr_i[1:0] == 2'd3)) en <= dat_i[0];
    end
  end

  // Register read multiplexer.
  always_comb begin
    rdata = '0;
    case (adr_i[1:0])
      2'd0: if (!empty) rdata = {1'b1, rd_ts, 7'b0, head[8:0]};
      2'd1: rdata = {16'b0, count_ext[7:0], 5'b0, ovf, full, empty};
      2'd2: rdata = {23'b0, thresh};
      2'd3: rdata = {31'b0, en};
      default: rdata = '0;
    endcase
  end

  // Bus response: ack one cycle after the access, read data held until the next read.
  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= access;
      if (bus_rd) dat_o <= rdata;
    end
  end

  assign cond = en & (thresh != 9'd0) & (count_ext >= thresh);

  // Interrupt strobe on each rising edge of the threshold condition.
  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      cond_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      cond_q <= cond;
      irq    <= cond & ~cond_q;
    end
  end

endmodule
